// File: rtl/nonrestoring_div_pkg.sv
// Shared types and sizing helpers for the non-restoring divider.
package div_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_Q = 4'd1,
    LOAD_M = 4'd2,
    CHK    = 4'd3,
    ITER   = 4'd4,
    CORR   = 4'd5,
    OUT_R  = 4'd6,
    OUT_Q  = 4'd7,
    DONE   = 4'd8
  } div_state_e;

  // Iteration counter width; at least one bit so W=1 still elaborates.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) begin
      cw = 1;
    end else begin
      cw = cw;
    end
    return cw;
  endfunction

endpackage

// File: rtl/nonrestoring_div_control_unit.sv
// Divider sequencer: state register, iteration counter and one-hot datapath strobes.
module div_control_unit
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bgn_i,
  input  logic m_zero_i,
  input  logic a_ge_m_i,
  output logic ld_a_o,
  output logic ld_q_o,
  output logic ld_m_o,
  output logic chk_o,
  output logic iter_o,
  output logic corr_o,
  output logic out_r_o,
  output logic out_q_o,
  output logic stop_o
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;

  // Sequencer state and iteration counter; the counter stops at W-1 so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bgn_i) state_q <= LOAD_Q;
        end
        LOAD_Q: state_q <= LOAD_M;
        LOAD_M: state_q <= CHK;
        CHK: begin
          if (m_zero_i || a_ge_m_i) begin
            state_q <= DONE;
          end else begin
            cnt_q   <= {CW{1'b0}};
            state_q <= ITER;
          end
        end
        ITER: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= CORR;
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        CORR:    state_q <= OUT_R;
        OUT_R:   state_q <= OUT_Q;
        OUT_Q:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are a pure decode of the registered state.
  always_comb begin
    ld_a_o  = 1'b0;
    ld_q_o  = 1'b0;
    ld_m_o  = 1'b0;
    chk_o   = 1'b0;
    iter_o  = 1'b0;
    corr_o  = 1'b0;
    out_r_o = 1'b0;
    out_q_o = 1'b0;
    stop_o  = 1'b0;
    case (state_q)
      IDLE:    ld_a_o  = bgn_i;
      LOAD_Q:  ld_q_o  = 1'b1;
      LOAD_M:  ld_m_o  = 1'b1;
      CHK:     chk_o   = 1'b1;
      ITER:    iter_o  = 1'b1;
      CORR:    corr_o  = 1'b1;
      OUT_R:   out_r_o = 1'b1;
      OUT_Q:   out_q_o = 1'b1;
      DONE:    stop_o  = 1'b1;
      default: stop_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/nonrestoring_div.sv
// Byte-serial unsigned non-restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
module nonrestoring_div
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         bgn,
  input  logic [W-1:0] ibus,
  output logic [W-1:0] obus,
  output logic         stop,
  output logic         ovf,
  output logic         dbz
);

  logic [W:0]   a_q, a_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] m_q, m_d;
  logic         ovf_q, ovf_d;
  logic         dbz_q, dbz_d;

  logic ld_a_s, ld_q_s, ld_m_s, chk_s, iter_s, corr_s, out_r_s, out_q_s, stop_s;
  logic m_zero_s, a_ge_m_s;

  logic [W:0] m_ext_s;
  logic [W:0] a_shift_s;
  logic [W:0] a_iter_s;

  assign m_zero_s  = (m_q == {W{1'b0}});
  assign a_ge_m_s  = (a_q[W-1:0] >= m_q);
  assign m_ext_s   = {1'b0, m_q};
  assign a_shift_s = {a_q[W-1:0], q_q[W-1]};

  div_control_unit #(.W(W)) u_ctrl (
    .clk      (clk),
    .rst_b    (rst_b),
    .bgn_i    (bgn),
    .m_zero_i (m_zero_s),
    .a_ge_m_i (a_ge_m_s),
    .ld_a_o   (ld_a_s),
    .ld_q_o   (ld_q_s),
    .ld_m_o   (ld_m_s),
    .chk_o    (chk_s),
    .iter_o   (iter_s),
    .corr_o   (corr_s),
    .out_r_o  (out_r_s),
    .out_q_o  (out_q_s),
    .stop_o   (stop_s)
  );

  // One non-restoring step: the sign of the old partial remainder selects subtract or add.
  always_comb begin
    if (a_q[W]) begin
      a_iter_s = a_shift_s + m_ext_s;
    end else begin
      a_iter_s = a_shift_s - m_ext_s;
    end
  end

  // Datapath next-state selection driven by the one-hot strobes.
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    if (ld_a_s) begin
      a_d   = {1'b0, ibus};
      ovf_d = 1'b0;
      dbz_d = 1'b0;
    end else if (ld_q_s) begin
      q_d = ibus;
    end else if (ld_m_s) begin
      m_d = ibus;
    end else if (chk_s) begin
      if (m_zero_s) begin
        dbz_d = 1'b1;
      end else if (a_ge_m_s) begin
        ovf_d = 1'b1;
      end else begin
        dbz_d = dbz_q;
      end
    end else if (iter_s) begin
      a_d = a_iter_s;
      q_d = {q_q[W-2:0], ~a_iter_s[W]};
    end else if (corr_s) begin
      if (a_q[W]) begin
        a_d = a_q + m_ext_s;
      end else begin
        a_d = a_q;
      end
    end else begin
      a_d = a_q;
    end
  end

  // Datapath and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      a_q   <= {(W+1){1'b0}};
      q_q   <= {W{1'b0}};
      m_q   <= {W{1'b0}};
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
    end
  end

  // Result bytes are only driven during the two unload states.
  always_comb begin
    if (out_r_s) begin
      obus = a_q[W-1:0];
    end else if (out_q_s) begin
      obus = q_q;
    end else begin
      obus = {W{1'b0}};
    end
  end

  assign stop = stop_s;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_nonrestoring_div.sv
// Directed bench for nonrestoring_div with hand-computed quotients, remainders and timing.
module tb_nonrestoring_div;

  logic       clk;
  logic       rst_b;
  logic       bgn;
  logic [7:0] ibus;
  logic [7:0] obus;
  logic       stop;
  logic       ovf;
  logic       dbz;

  int checks;
  int failures;

  nonrestoring_div #(.W(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bgn   (bgn),
    .ibus  (ibus),
    .obus  (obus),
    .stop  (stop),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // err: 0 = normal, 1 = overflow, 2 = divide-by-zero. Starts and ends in an IDLE cycle.
  task automatic run_op(input string name, input logic [7:0] hi, input logic [7:0] lo,
                        input logic [7:0] dv, input int err, input logic [7:0] exp_r,
                        input logic [7:0] exp_q, input bit pulse, input bit hold);
    int done_p;
    logic [7:0] exp_ob;
    done_p = (err != 0) ? 4 : 15;
    ibus = hi;
    bgn  = 1'b1;
    tick();
    check({name, " c1 ovf"}, {7'd0, ovf}, 8'd0);
    check({name, " c1 dbz"}, {7'd0, dbz}, 8'd0);
    check({name, " c1 stop"}, {7'd0, stop}, 8'd0);
    bgn  = hold;
    ibus = lo;
    tick();
    ibus = dv;
    for (int p = 3; p <= done_p; p++) begin
      bgn = hold | (pulse & ((p == 6) | (p == 7)));
      tick();
      ibus = (pulse && p >= 5 && p <= 7) ? 8'hA5 : 8'h00;
      if (err == 0 && p == 13) exp_ob = exp_r;
      else if (err == 0 && p == 14) exp_ob = exp_q;
      else exp_ob = 8'h00;
      check($sformatf("%s c%0d obus", name, p), obus, exp_ob);
      check($sformatf("%s c%0d stop", name, p), {7'd0, stop}, {7'd0, (p == done_p)});
      check($sformatf("%s c%0d ovf", name, p), {7'd0, ovf}, {7'd0, (err == 1 && p >= 4)});
      check($sformatf("%s c%0d dbz", name, p), {7'd0, dbz}, {7'd0, (err == 2 && p >= 4)});
    end
    ibus = 8'h00;
    bgn  = hold;
    tick();
    check({name, " idle stop"}, {7'd0, stop}, 8'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_b    = 1'b0;
    bgn      = 1'b0;
    ibus     = 8'h00;
    tick();
    tick();
    check("reset obus", obus, 8'h00);
    check("reset stop", {7'd0, stop}, 8'd0);
    check("reset ovf", {7'd0, ovf}, 8'd0);
    check("reset dbz", {7'd0, dbz}, 8'd0);
    rst_b = 1'b1;
    tick();

    run_op("100/7",   8'h00, 8'h64, 8'h07, 0, 8'h02, 8'h0E, 1'b0, 1'b0);
    run_op("255/16",  8'h00, 8'hFF, 8'h10, 0, 8'h0F, 8'h0F, 1'b0, 1'b0);
    run_op("65025/255", 8'hFE, 8'h01, 8'hFF, 0, 8'h00, 8'hFF, 1'b0, 1'b0);
    run_op("dbz",     8'h12, 8'h34, 8'h00, 2, 8'h00, 8'h00, 1'b0, 1'b0);
    check("dbz held in idle", {7'd0, dbz}, 8'd1);
    run_op("after dbz", 8'h00, 8'h64, 8'h07, 0, 8'h02, 8'h0E, 1'b0, 1'b0);
    run_op("ovf",     8'h07, 8'h00, 8'h07, 1, 8'h00, 8'h00, 1'b0, 1'b0);
    check("ovf held in idle", {7'd0, ovf}, 8'd1);
    run_op("1791/7",  8'h06, 8'hFF, 8'h07, 0, 8'h06, 8'hFF, 1'b0, 1'b0);
    run_op("zero/5",  8'h00, 8'h00, 8'h05, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("bgn pulse", 8'h00, 8'h64, 8'h07, 0, 8'h02, 8'h0E, 1'b1, 1'b0);

    // Reset in IDLE clears a held flag.
    run_op("dbz2",    8'h01, 8'h00, 8'h00, 2, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_b = 1'b0;
    tick();
    check("idle reset dbz", {7'd0, dbz}, 8'd0);
    rst_b = 1'b1;

    // Reset during ITER: nothing must come out afterwards.
    ibus = 8'h00;
    bgn  = 1'b1;
    tick();
    bgn  = 1'b0;
    ibus = 8'h64;
    tick();
    ibus = 8'h07;
    tick();
    ibus = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    rst_b = 1'b0;
    tick();
    check("midreset obus", obus, 8'h00);
    check("midreset stop", {7'd0, stop}, 8'd0);
    check("midreset ovf", {7'd0, ovf}, 8'd0);
    check("midreset dbz", {7'd0, dbz}, 8'd0);
    rst_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("post-reset quiet obus %0d", i), obus, 8'h00);
      check($sformatf("post-reset quiet stop %0d", i), {7'd0, stop}, 8'd0);
    end
    run_op("fresh 100/7", 8'h00, 8'h64, 8'h07, 0, 8'h02, 8'h0E, 1'b0, 1'b0);

    // bgn held high: second op's cycle 0 is the IDLE cycle right after DONE.
    run_op("b2b first",  8'h00, 8'h64, 8'h07, 0, 8'h02, 8'h0E, 1'b0, 1'b1);
    run_op("b2b second", 8'h00, 8'hFF, 8'h10, 0, 8'h0F, 8'h0F, 1'b0, 1'b1);
    bgn = 1'b0;
    tick();
    check("b2b final idle obus", obus, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
